// File: rtl/erasure_locator_engine.sv
`default_nettype none
// ============================================================================
// Module      : erasure_locator_engine
// Description : Builds the Reed-Solomon erasure locator polynomial
//               Lambda(x) = prod(1 + X_k x) over GF(2^SYM_W), then streams
//               its coefficients out over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module erasure_locator_engine #(
    parameter int               SYM_W    = 8,
    parameter int               MAX_ERAS = 16,
    parameter int               CNT_W    = 5,
    parameter logic [SYM_W:0]   POLY     = 9'h11D
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_erasures,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SYM_W-1:0]    in_locator,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [CNT_W-1:0]    degree,
    input  logic                read_start,
    output logic                coef_valid,
    input  logic                coef_ready,
    output logic [SYM_W-1:0]    coef_data,
    output logic [CNT_W-1:0]    coef_idx,
    output logic                coef_last
);

    localparam logic [CNT_W-1:0] c_MAX_ERAS = CNT_W'(MAX_ERAS);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_UPDATE  = 3'd2,
        S_DONE    = 3'd3,
        S_READ    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [SYM_W-1:0]   r_lambda [0:MAX_ERAS];
    logic [SYM_W-1:0]   r_x;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_num;
    logic [CNT_W-1:0]   r_i;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_degree;
    logic               r_done;
    logic               r_overflow;

    logic               w_start_acc;
    logic               w_start_short;
    logic               w_upd_last;
    logic               w_finish;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [SYM_W-1:0]   w_prod;

    // Shift-and-add multiply, reducing by POLY each time the top bit falls out.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] acc;
        logic [SYM_W-1:0] sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < SYM_W; k++) begin
            if (b[k])
                acc = acc ^ sh;
            if (sh[SYM_W-1])
                sh = (sh << 1) ^ POLY[SYM_W-1:0];
            else
                sh = sh << 1;
        end
        return acc;
    endfunction

    assign w_start_acc   = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_start_short = (num_erasures == '0) || (num_erasures > c_MAX_ERAS);
    assign w_cnt_inc     = r_cnt + c_ONE;
    assign w_upd_last    = (r_state == S_UPDATE) && (r_i == c_ONE);
    assign w_finish      = w_upd_last && (w_cnt_inc == r_num);
    // Single shared multiplier; r_i >= 1 whenever the product is consumed.
    assign w_prod        = gf_mul(r_x, r_lambda[r_i - c_ONE]);

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        coef_valid = 1'b0;
        coef_data  = '0;
        coef_idx   = '0;
        coef_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    w_next = w_start_short ? S_DONE : S_COLLECT;
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid)
                    w_next = S_UPDATE;
            end
            S_UPDATE: begin
                if (w_upd_last)
                    w_next = w_finish ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                busy = 1'b0;
                if (start)
                    w_next = w_start_short ? S_DONE : S_COLLECT;
                else if (read_start)
                    w_next = S_READ;
            end
            S_READ: begin
                coef_valid = 1'b1;
                coef_data  = r_lambda[r_idx];
                coef_idx   = r_idx;
                coef_last  = (r_idx == r_degree);
                if (coef_ready && (r_idx == r_degree))
                    w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k <= MAX_ERAS; k++)
                r_lambda[k] <= (k == 0) ? SYM_W'(1) : '0;
            r_x        <= '0;
            r_cnt      <= '0;
            r_num      <= '0;
            r_i        <= '0;
            r_idx      <= '0;
            r_degree   <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_acc) begin
                for (int k = 0; k <= MAX_ERAS; k++)
                    r_lambda[k] <= (k == 0) ? SYM_W'(1) : '0;
                r_cnt      <= '0;
                r_degree   <= '0;
                r_num      <= num_erasures;
                r_overflow <= (num_erasures > c_MAX_ERAS);
                r_done     <= w_start_short;
            end else begin
                if (r_state == S_COLLECT && in_valid) begin
                    r_x <= in_locator;
                    r_i <= w_cnt_inc;
                end
                // Descending index keeps lambda[i-1] un-updated when it is read.
                if (r_state == S_UPDATE) begin
                    r_lambda[r_i] <= r_lambda[r_i] ^ w_prod;
                    r_i           <= r_i - c_ONE;
                    if (w_upd_last)
                        r_cnt <= w_cnt_inc;
                    if (w_finish) begin
                        r_done   <= 1'b1;
                        r_degree <= r_num;
                    end
                end
                if (r_state == S_DONE && read_start)
                    r_idx <= '0;
                if (r_state == S_READ && coef_ready)
                    r_idx <= r_idx + c_ONE;
            end
        end
    end

    assign done     = r_done;
    assign overflow = r_overflow;
    assign degree   = r_degree;

endmodule
`default_nettype wire

// File: tb/tb_erasure_locator_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_erasure_locator_engine
// Description : Directed self-checking bench for erasure_locator_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_erasure_locator_engine;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] num_erasures = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_locator = '0;
    logic       busy;
    logic       done;
    logic       overflow;
    logic [4:0] degree;
    logic       read_start = 1'b0;
    logic       coef_valid;
    logic       coef_ready = 1'b0;
    logic [7:0] coef_data;
    logic [4:0] coef_idx;
    logic       coef_last;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_c [0:3];

    always #5 clock = ~clock;

    erasure_locator_engine #(
        .SYM_W(8), .MAX_ERAS(16), .CNT_W(5), .POLY(9'h11D)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .num_erasures(num_erasures),
        .in_valid(in_valid), .in_ready(in_ready), .in_locator(in_locator),
        .busy(busy), .done(done), .overflow(overflow), .degree(degree),
        .read_start(read_start), .coef_valid(coef_valid), .coef_ready(coef_ready),
        .coef_data(coef_data), .coef_idx(coef_idx), .coef_last(coef_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [4:0] n);
        start = 1'b1;
        num_erasures = n;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Hands over one locator and measures UPDATE cycles until in_ready or done.
    task automatic send(input logic [7:0] x, input int exp_gap, input bit last);
        int w;
        int gap;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid   = 1'b1;
        in_locator = x;
        @(negedge clock);
        in_valid = 1'b0;
        gap = 0;
        while (!in_ready && !done && gap < 50) begin
            gap++;
            @(negedge clock);
        end
        check("update_gap", gap, exp_gap);
        check(last ? "done_after_last" : "no_done_mid", done, last);
    endtask

    // Expected values are checked every cycle, so stalls also prove stability.
    task automatic readout(input int n, input bit rnd);
        int k;
        int cyc;
        bit rdy;
        k = 0;
        cyc = 0;
        read_start = 1'b1;
        @(negedge clock);
        read_start = 1'b0;
        while (k < n && cyc < 200) begin
            check("coef_valid", coef_valid, 1);
            check("coef_data", coef_data, exp_c[k]);
            check("coef_idx", coef_idx, k);
            check("coef_last", coef_last, (k == n - 1));
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            coef_ready = rdy;
            @(negedge clock);
            coef_ready = 1'b0;
            if (rdy)
                k++;
            cyc++;
        end
        check("read_count", k, n);
        check("read_end_valid", coef_valid, 0);
        check("read_end_busy", busy, 0);
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_degree", degree, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_coef_valid", coef_valid, 0);
        check("rst_coef_data", coef_data, 0);
        check("rst_coef_idx", coef_idx, 0);
        check("rst_coef_last", coef_last, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_busy", busy, 0);

        // Zero erasures: immediate done, constant polynomial
        do_start(5'd0);
        check("z_done", done, 1);
        check("z_degree", degree, 0);
        check("z_busy", busy, 0);
        check("z_overflow", overflow, 0);
        @(negedge clock);
        check("z_done_single", done, 0);
        exp_c = '{8'h01, 8'h00, 8'h00, 8'h00};
        readout(1, 1'b0);

        // start beats read_start in DONE
        start = 1'b1;
        num_erasures = 5'd1;
        read_start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        read_start = 1'b0;
        check("prio_no_read", coef_valid, 0);
        check("prio_collect", in_ready, 1);
        check("prio_busy", busy, 1);

        // One erasure X=02
        send(8'h02, 1, 1'b1);
        check("n1_degree", degree, 1);
        exp_c = '{8'h01, 8'h02, 8'h00, 8'h00};
        readout(2, 1'b0);

        // Two erasures 02,04; stray start in COLLECT is ignored
        do_start(5'd2);
        send(8'h02, 1, 1'b0);
        start = 1'b1;
        num_erasures = 5'd0;
        @(negedge clock);
        start = 1'b0;
        check("ign_start_done", done, 0);
        check("ign_start_ready", in_ready, 1);
        send(8'h04, 2, 1'b1);
        check("n2_degree", degree, 2);
        exp_c = '{8'h01, 8'h06, 8'h08, 8'h00};
        readout(3, 1'b0);

        // Field reduction: (1+80x)(1+02x) = 1 + 82x + 1Dx^2
        do_start(5'd2);
        send(8'h80, 1, 1'b0);
        send(8'h02, 2, 1'b1);
        exp_c = '{8'h01, 8'h82, 8'h1D, 8'h00};
        readout(3, 1'b0);

        // Overflow: 17 > 16
        do_start(5'd17);
        check("ov_done", done, 1);
        check("ov_flag", overflow, 1);
        check("ov_degree", degree, 0);
        check("ov_in_ready", in_ready, 0);
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (in_ready || busy)
                bad++;
        end
        check("ov_never_ready", bad, 0);
        check("ov_held", overflow, 1);
        exp_c = '{8'h01, 8'h00, 8'h00, 8'h00};
        readout(1, 1'b0);

        // Three erasures with random backpressure, read twice
        do_start(5'd3);
        check("ov_cleared", overflow, 0);
        send(8'h02, 1, 1'b0);
        send(8'h04, 2, 1'b0);
        send(8'h08, 3, 1'b1);
        check("n3_degree", degree, 3);
        exp_c = '{8'h01, 8'h0E, 8'h38, 8'h40};
        readout(4, 1'b1);
        readout(4, 1'b1);

        // Reset mid-UPDATE aborts without done
        do_start(5'd2);
        in_valid = 1'b1;
        in_locator = 8'h05;
        @(negedge clock);
        in_valid = 1'b0;
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ready", in_ready, 0);
        check("abort_degree", degree, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (done)
                bad++;
        end
        check("abort_no_stale_done", bad, 0);
        do_start(5'd1);
        send(8'h03, 1, 1'b1);
        exp_c = '{8'h01, 8'h03, 8'h00, 8'h00};
        readout(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
